// File: rtl/sha256_compress_iter_if.sv
// Handshake and result bundle between the SHA-224/256 compression engine,
// the message-schedule unit (w_*) and the padding/top controller (start, digest).
interface sha256_compress_iter_if #(
    parameter int R = 1
);
    logic              start;
    logic              first_blk;
    logic              mode_224;
    logic              w_valid;
    logic [32*R-1:0]   w_data;
    logic              w_ready;
    logic              busy;
    logic              done;
    logic              digest_valid;
    logic [255:0]      digest;

    modport master (
        output start, first_blk, mode_224, w_valid, w_data,
        input  w_ready, busy, done, digest_valid, digest
    );

    modport slave (
        input  start, first_blk, mode_224, w_valid, w_data,
        output w_ready, busy, done, digest_valid, digest
    );
endinterface

// File: rtl/sha256_compress_iter.sv
// SHA-224/SHA-256 compression engine applying R rounds per accepted schedule beat,
// chaining blocks through an internally held H register.
module sha256_compress_iter #(
    parameter int R        = 1,
    parameter int NUM_RNDS = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    sha256_compress_iter_if.slave   bus
);

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
            $error("sha256_compress_iter: R must be 1, 2, 4 or 8");
        end
        if ((NUM_RNDS % R) != 0 || NUM_RNDS > 64 || NUM_RNDS < R) begin : g_bad_rnds
            $error("sha256_compress_iter: NUM_RNDS must be a multiple of R and at most 64");
        end
        if ($bits(bus.w_data) != 32 * R) begin : g_bad_bus
            $error("sha256_compress_iter: interface R does not match engine R");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    localparam logic [6:0]   LAST_J = 7'(NUM_RNDS - R);
    localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224  = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One FIPS 180-4 round on the packed {a,b,c,d,e,f,g,h} working state.
    function automatic logic [255:0] sha_round(input logic [255:0] st, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    state_t        state_r;
    logic          first_r;
    logic          mode_r;
    logic [6:0]    j_r;
    logic [255:0]  st_r;
    logic [255:0]  base_r;
    logic [255:0]  h_r;
    logic [255:0]  digest_r;
    logic          busy_r;
    logic          done_r;
    logic          w_ready_r;
    logic          dv_r;

    logic [255:0]  rnd_s;
    logic [255:0]  load_s;
    logic [255:0]  sum_s;
    logic          eff_first_s;

    assign sum_s       = add_words(base_r, st_r);
    assign eff_first_s = bus.first_blk | ~dv_r;

    // R rounds chained combinationally from the current working state.
    always_comb begin
        rnd_s = st_r;
        for (int i = 0; i < R; i++) begin
            rnd_s = sha_round(rnd_s, K_TAB[6'(j_r + 7'(i))], bus.w_data[32*i +: 32]);
        end
    end

    // Block initial value: IV for a fresh message, otherwise the held digest.
    always_comb begin
        if (first_r) begin
            if (mode_r) begin
                load_s = IV224;
            end else begin
                load_s = IV256;
            end
        end else begin
            load_s = h_r;
        end
    end

    // Control FSM with working state, digest and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            first_r   <= 1'b0;
            mode_r    <= 1'b0;
            j_r       <= 7'd0;
            st_r      <= 256'd0;
            base_r    <= 256'd0;
            h_r       <= 256'd0;
            digest_r  <= 256'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_ready_r <= 1'b0;
            dv_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r <= S_LOAD;
                        busy_r  <= 1'b1;
                        first_r <= eff_first_s;
                        // Chained blocks keep the mode of the message they extend.
                        if (eff_first_s) begin
                            mode_r <= bus.mode_224;
                        end else begin
                            mode_r <= mode_r;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    st_r      <= load_s;
                    base_r    <= load_s;
                    j_r       <= 7'd0;
                    w_ready_r <= 1'b1;
                    state_r   <= S_ROUND;
                end
                S_ROUND: begin
                    if (bus.w_valid) begin
                        st_r <= rnd_s;
                        j_r  <= j_r + 7'(R);
                        if (j_r == LAST_J) begin
                            state_r   <= S_FINAL;
                            w_ready_r <= 1'b0;
                        end else begin
                            state_r <= S_ROUND;
                        end
                    end else begin
                        state_r <= S_ROUND;
                    end
                end
                S_FINAL: begin
                    h_r <= sum_s;
                    if (mode_r) begin
                        digest_r <= {sum_s[255:32], 32'h0000_0000};
                    end else begin
                        digest_r <= sum_s;
                    end
                    dv_r    <= 1'b1;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    w_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w_ready      = w_ready_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.digest_valid = dv_r;
    assign bus.digest       = digest_r;

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench for sha256_compress_iter: an R=1 and an R=4 engine fed by a
// bench-side message schedule, checked against published SHA-224/256 digests.
module tb_sha256_compress_iter;

    localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha256_compress_iter_if #(.R(1)) if1 ();
    sha256_compress_iter_if #(.R(4)) if4 ();

    sha256_compress_iter #(.R(1), .NUM_RNDS(64)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    sha256_compress_iter #(.R(4), .NUM_RNDS(64)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int done_cnt1 = 0;

    logic [31:0] w_tab [64];
    logic [31:0] blk_abc [16];
    logic [31:0] blk_m1 [16];
    logic [31:0] blk_m2 [16];

    int last_cyc, last_stalls, last_ready;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (if1.done) done_cnt1 <= done_cnt1 + 1;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion, standing in for the upstream schedule unit.
    task automatic load_sched(input logic [31:0] b [16]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w_tab[t] = b[t];
            end else begin
                s0 = rr(w_tab[t-15], 7) ^ rr(w_tab[t-15], 18) ^ (w_tab[t-15] >> 3);
                s1 = rr(w_tab[t-2], 17) ^ rr(w_tab[t-2], 19) ^ (w_tab[t-2] >> 10);
                w_tab[t] = s1 + w_tab[t-7] + s0 + w_tab[t-16];
            end
        end
    endtask

    task automatic drv(input int sel, input logic st, input logic fb, input logic m,
                       input logic wv, input logic [127:0] wd);
        if (sel == 0) begin
            if1.start = st; if1.first_blk = fb; if1.mode_224 = m;
            if1.w_valid = wv; if1.w_data = wd[31:0];
        end else begin
            if4.start = st; if4.first_blk = fb; if4.mode_224 = m;
            if4.w_valid = wv; if4.w_data = wd;
        end
    endtask

    function automatic logic g_done(input int sel);
        return (sel == 0) ? if1.done : if4.done;
    endfunction
    function automatic logic g_ready(input int sel);
        return (sel == 0) ? if1.w_ready : if4.w_ready;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel == 0) ? if1.busy : if4.busy;
    endfunction
    function automatic logic g_dv(input int sel);
        return (sel == 0) ? if1.digest_valid : if4.digest_valid;
    endfunction
    function automatic logic [255:0] g_dig(input int sel);
        return (sel == 0) ? if1.digest : if4.digest;
    endfunction

    // Runs one block from the current negedge; returns at the negedge where done is seen.
    task automatic run_blk(input int sel, input logic first, input logic mode, input int stall_pct,
                           input int abort_beat, input bit poke);
        int cyc, beats, stalls, rdy, nbeats, bi;
        bit seen;
        logic wv, pk;
        logic [127:0] wd;
        nbeats = (sel == 0) ? 64 : 16;
        drv(sel, 1'b1, first, mode, 1'b0, 128'd0);
        @(negedge clk);
        cyc = 0; beats = 0; stalls = 0; rdy = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (cyc == 0) begin
                check_eq("load_w_ready", 256'(g_ready(sel)), 256'd0);
                check_eq("load_busy", 256'(g_busy(sel)), 256'd1);
            end
            if (abort_beat >= 0 && beats == abort_beat) begin
                reset = 1'b1;
                drv(sel, 1'b0, first, mode, 1'b0, 128'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (g_done(sel)) begin
                seen = 1'b1;
                drv(sel, 1'b0, first, mode, 1'b0, 128'd0);
            end else begin
                wv = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
                bi = (beats < nbeats) ? beats : nbeats - 1;
                if (sel == 0) wd = {96'd0, w_tab[bi]};
                else          wd = {w_tab[4*bi+3], w_tab[4*bi+2], w_tab[4*bi+1], w_tab[4*bi]};
                pk = poke && (cyc == 0 || cyc == 10 || cyc == 65);
                drv(sel, pk, pk ? 1'b1 : first, pk ? 1'b1 : mode, wv, wd);
                if (g_ready(sel)) begin
                    rdy++;
                    if (wv) beats++;
                    else    stalls++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("done_seen", 256'(seen), 256'd1);
        last_cyc = cyc; last_stalls = stalls; last_ready = rdy;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, d0;
        blk_abc = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
        blk_m1  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_m2  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
        reset = 1'b1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);
        drv(1, 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_busy", 256'(g_busy(s)), 256'd0);
            check_eq("rst_done", 256'(g_done(s)), 256'd0);
            check_eq("rst_w_ready", 256'(g_ready(s)), 256'd0);
            check_eq("rst_digest_valid", 256'(g_dv(s)), 256'd0);
            check_eq("rst_digest", g_dig(s), 256'd0);
        end

        // 1: SHA-256 "abc", R=1
        load_sched(blk_abc);
        run_blk(0, 1'b1, 1'b0, 0, -1, 1'b0);
        check_eq("t1_latency", 256'(last_cyc), 256'd66);
        check_eq("t1_digest", if1.digest, D_ABC256);
        check_eq("t1_digest_valid", 256'(if1.digest_valid), 256'd1);
        check_eq("t1_ready_cycles", 256'(last_ready), 256'd64);
        @(negedge clk);
        check_eq("t1_done_one_cycle", 256'(if1.done), 256'd0);
        check_eq("t1_digest_hold", if1.digest, D_ABC256);

        // 2: SHA-224 "abc"
        run_blk(0, 1'b1, 1'b1, 0, -1, 1'b0);
        check_eq("t2_latency", 256'(last_cyc), 256'd66);
        check_eq("t2_digest", if1.digest, D_ABC224);

        // 3: two-block message, R=4, second block started in the done cycle
        @(negedge clk);
        load_sched(blk_m1);
        run_blk(1, 1'b1, 1'b0, 0, -1, 1'b0);
        check_eq("t3_blk1_latency", 256'(last_cyc), 256'd18);
        t1 = cyc_cnt;
        load_sched(blk_m2);
        run_blk(1, 1'b0, 1'b0, 0, -1, 1'b0);
        check_eq("t3_blk2_latency", 256'(last_cyc), 256'd18);
        check_eq("t3_done_spacing", 256'(cyc_cnt - t1), 256'd19);
        check_eq("t3_digest", if4.digest, D_TWO);

        // 4: "abc" with random stalls
        @(negedge clk);
        load_sched(blk_abc);
        run_blk(0, 1'b1, 1'b0, 30, -1, 1'b0);
        check_eq("t4_stalls_seen", 256'(last_stalls > 0), 256'd1);
        check_eq("t4_latency", 256'(last_cyc), 256'(66 + last_stalls));
        check_eq("t4_ready_cycles", 256'(last_ready), 256'(64 + last_stalls));
        check_eq("t4_digest", if1.digest, D_ABC256);
        @(negedge clk);
        check_eq("t4_ready_idle", 256'(if1.w_ready), 256'd0);

        // 5: reset at round 30, then restart with first_blk=0
        run_blk(0, 1'b1, 1'b0, 0, 30, 1'b0);
        check_eq("t5_dv_after_reset", 256'(if1.digest_valid), 256'd0);
        check_eq("t5_busy_after_reset", 256'(if1.busy), 256'd0);
        check_eq("t5_digest_after_reset", if1.digest, 256'd0);
        run_blk(0, 1'b0, 1'b0, 0, -1, 1'b0);
        check_eq("t5_latency", 256'(last_cyc), 256'd66);
        check_eq("t5_digest", if1.digest, D_ABC256);

        // 6: start pulses while busy are ignored
        @(negedge clk);
        d0 = done_cnt1;
        run_blk(0, 1'b1, 1'b0, 0, -1, 1'b1);
        check_eq("t6_latency", 256'(last_cyc), 256'd66);
        check_eq("t6_digest", if1.digest, D_ABC256);
        repeat (80) @(negedge clk);
        check_eq("t6_done_count", 256'(done_cnt1 - d0), 256'd1);
        check_eq("t6_idle_busy", 256'(if1.busy), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
